vx_avs_responder: RTL and testbench
===================================

VX_AVS_RESPONDER -- requirements
Module: VX_avs_responder

Interface
REQ-001 SHALL have parameter AVS_DATAW, default 512, data bus width in bits.
REQ-002 SHALL have parameter AVS_ADDRW, default 25, word address width.
REQ-003 SHALL have parameter AVS_BURSTW, default 4, burstcount width.
REQ-004 SHALL have parameter AVS_BANKS, default 2, bank count; AVS_BANKS_BITS = max(1, clog2(AVS_BANKS)).
REQ-005 SHALL have parameter MEM_ADDRW, default 10, log2 of words stored per bank.
REQ-006 SHALL have parameter READ_LATENCY, default 4, accept-to-readdatavalid cycles (>=1).
REQ-007 SHALL have parameter MAX_PENDING, default 8, outstanding read limit (>=1); AVS_BYTEENW = AVS_DATAW/8.
REQ-008 SHALL have ports: clk in 1, clock; reset_n in 1, asynchronous active-low reset.
REQ-009 SHALL have ports: avs_address in AVS_ADDRW; avs_bankselect in AVS_BANKS_BITS; avs_read in 1; avs_write in 1; avs_writedata in AVS_DATAW; avs_byteenable in AVS_BYTEENW; avs_burstcount in AVS_BURSTW.
REQ-010 SHALL have ports: avs_waitrequest out 1; avs_readdata out AVS_DATAW; avs_readdatavalid out 1; error out 1, sticky protocol-error flag.

Function
REQ-011 SHALL accept a request in a cycle where (avs_read|avs_write) && !avs_waitrequest; one request per cycle, at most.
REQ-012 SHALL drive avs_waitrequest only from internal state (pending count, stall state), never combinationally from avs_read/avs_write.
REQ-013 SHALL assert avs_waitrequest when pending == MAX_PENDING, where pending counts accepted reads whose readdatavalid has not yet been issued.
REQ-014 SHALL index storage as {avs_bankselect, avs_address[MEM_ADDRW-1:0]}; upper address bits ignored (aliasing); bankselect >= AVS_BANKS wraps modulo 2^AVS_BANKS_BITS.
REQ-015 SHALL on accepted write update only bytes with avs_byteenable set, visible to any read accepted in a later cycle.
REQ-016 SHALL on accepted read snapshot the addressed word at acceptance and return it with avs_readdatavalid=1 for exactly one cycle, READ_LATENCY cycles after the accept edge.
REQ-017 SHALL return read data strictly in acceptance order; back-to-back reads produce back-to-back readdatavalid.
REQ-018 SHALL hold avs_readdata at its last returned value when avs_readdatavalid=0.
REQ-019 SHALL update pending +1 on read accept, -1 on readdatavalid, unchanged on both in the same cycle; width clog2(MAX_PENDING+1); no overflow or underflow.
REQ-020 SHALL treat avs_read && avs_write together as a write only and set error.
REQ-021 SHALL treat avs_burstcount != 1 on an accepted request as a single beat and set error.
REQ-022 SHALL keep error high once set until reset.

Reset
REQ-023 SHALL on reset_n low asynchronously force avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0, error=0, pending=0, and flush the read pipeline.
REQ-024 SHALL discard reads in flight when reset asserts mid-operation; no readdatavalid for them after release.
REQ-025 SHALL NOT reset memory contents; the array retains its data across reset.
REQ-026 SHALL deassert avs_waitrequest on the first clock edge after reset_n rises (absent stall injection).

Configuration
REQ-027 SHALL with macro AVS_STALL_INJECT_EN defined include a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) that advances every cycle.
REQ-028 SHALL with AVS_STALL_INJECT_EN additionally assert avs_waitrequest when lfsr[1:0]==2'b00.
REQ-029 SHALL without AVS_STALL_INJECT_EN contain no LFSR, with waitrequest governed by REQ-013 only.

Verification
REQ-030 SHALL cover: write addr 5 bank 0 data 0xAA..AA byteen all-ones, then read addr 5 -> readdatavalid exactly 4 cycles after read accept with data 0xAA..AA.
REQ-031 SHALL cover: write 0x11..11 to addr 7, then write 0xFF..FF with byteen 0x1 -> read returns 0x11..11FF.
REQ-032 SHALL cover: 9 consecutive reads with MAX_PENDING=8, READ_LATENCY=16 -> waitrequest high after 8th accept; 9th accepted the cycle after first readdatavalid; data returned in order.
REQ-033 SHALL cover: avs_read and avs_write both high, and burstcount=2 on a read -> error=1 and sticky; write performed; read returns one beat.
REQ-034 SHALL cover: reset_n pulsed low with 3 reads in flight -> no readdatavalid afterwards, pending=0, previously written data still readable.
REQ-035 SHALL cover: with AVS_STALL_INJECT_EN, 1000 random requests -> waitrequest observed high with pending<MAX_PENDING, all reads return correct data in order.

Source files
------------

// File: rtl/vx_avs_responder_if.sv
// Avalon-MM slave bus bundle for vx_avs_responder.
// master: the requester side; slave: the responder side.
interface vx_avs_responder_if #(
    parameter int AVS_DATAW  = 512,
    parameter int AVS_ADDRW  = 25,
    parameter int AVS_BURSTW = 4,
    parameter int AVS_BANKS  = 2
);
    localparam int AVS_BANKS_BITS = (AVS_BANKS > 1) ? $clog2(AVS_BANKS) : 1;
    localparam int AVS_BYTEENW    = AVS_DATAW / 8;

    logic [AVS_ADDRW-1:0]      avs_address;
    logic [AVS_BANKS_BITS-1:0] avs_bankselect;
    logic                      avs_read;
    logic                      avs_write;
    logic [AVS_DATAW-1:0]      avs_writedata;
    logic [AVS_BYTEENW-1:0]    avs_byteenable;
    logic [AVS_BURSTW-1:0]     avs_burstcount;
    logic                      avs_waitrequest;
    logic [AVS_DATAW-1:0]      avs_readdata;
    logic                      avs_readdatavalid;
    logic                      error;

    modport master (
        output avs_address, avs_bankselect, avs_read, avs_write,
               avs_writedata, avs_byteenable, avs_burstcount,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid, error
    );

    modport slave (
        input  avs_address, avs_bankselect, avs_read, avs_write,
               avs_writedata, avs_byteenable, avs_burstcount,
        output avs_waitrequest, avs_readdata, avs_readdatavalid, error
    );
endinterface

// File: rtl/vx_avs_responder.sv
// Banked Avalon-MM memory responder with fixed read latency.
// Reads snapshot the word at accept time and return it READ_LATENCY cycles
// later, in order. waitrequest depends only on internal state.
// Optional macro AVS_STALL_INJECT_EN adds LFSR-driven random stalls.
module vx_avs_responder #(
    parameter int AVS_DATAW    = 512,
    parameter int AVS_ADDRW    = 25,
    parameter int AVS_BURSTW   = 4,
    parameter int AVS_BANKS    = 2,
    parameter int MEM_ADDRW    = 10,
    parameter int READ_LATENCY = 4,
    parameter int MAX_PENDING  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    vx_avs_responder_if.slave   avs
);
    localparam int AVS_BANKS_BITS = (AVS_BANKS > 1) ? $clog2(AVS_BANKS) : 1;
    localparam int AVS_BYTEENW    = AVS_DATAW / 8;
    localparam int IDXW           = AVS_BANKS_BITS + MEM_ADDRW;
    localparam int MEM_DEPTH      = 1 << IDXW;
    localparam int PENDW          = $clog2(MAX_PENDING + 1);

    // storage is deliberately never reset so contents survive reset_n
    logic [AVS_DATAW-1:0] mem [MEM_DEPTH];

    logic                                      rdy_q, rdy_d;
    logic [PENDW-1:0]                          pending_q, pending_d;
    logic                                      error_q, error_d;
    logic [READ_LATENCY-1:0]                   vld_pipe_q, vld_pipe_d;
    logic [READ_LATENCY-1:0][AVS_DATAW-1:0]    dat_pipe_q, dat_pipe_d;

    logic                 stall;
    logic                 wait_req;
    logic                 accept;
    logic                 do_write;
    logic                 do_read;
    logic                 rsp_vld;
    logic [IDXW-1:0]      idx;
    logic [AVS_DATAW-1:0] rd_word;

    // upper address bits alias onto the same storage
    generate
        if (AVS_ADDRW > MEM_ADDRW) begin : g_unused_addr
            logic unused_addr;
            assign unused_addr = ^avs.avs_address[AVS_ADDRW-1:MEM_ADDRW];
        end
    endgenerate

`ifdef AVS_STALL_INJECT_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free running
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR state register, reseeded on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_q <= 16'hACE1;
        else          lfsr_q <= lfsr_d;
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign wait_req = !rdy_q || (pending_q == PENDW'(MAX_PENDING)) || stall;
    assign accept   = (avs.avs_read || avs.avs_write) && !wait_req;
    // read+write together is handled as a write only
    assign do_write = accept && avs.avs_write;
    assign do_read  = accept && avs.avs_read && !avs.avs_write;
    assign idx      = {avs.avs_bankselect, avs.avs_address[MEM_ADDRW-1:0]};
    assign rd_word  = mem[idx];
    assign rsp_vld  = vld_pipe_q[READ_LATENCY-1];

    // byte-masked write into the array
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < AVS_BYTEENW; b++) begin
                if (avs.avs_byteenable[b]) mem[idx][b*8 +: 8] <= avs.avs_writedata[b*8 +: 8];
            end
        end
    end

    // next-state: ready flag, pending count, sticky error, read pipeline
    always_comb begin
        rdy_d = 1'b1;

        pending_d = pending_q;
        case ({do_read, rsp_vld})
            2'b10:   pending_d = pending_q + PENDW'(1);
            2'b01:   pending_d = pending_q - PENDW'(1);
            default: pending_d = pending_q;
        endcase

        // every accepted request is a single beat; any other burstcount is flagged
        error_d = error_q ||
                  (accept && ((avs.avs_read && avs.avs_write) ||
                              (avs.avs_burstcount != AVS_BURSTW'(1))));

        // data stages load only behind a valid so the last stage holds
        vld_pipe_d    = vld_pipe_q;
        dat_pipe_d    = dat_pipe_q;
        vld_pipe_d[0] = do_read;
        if (do_read) dat_pipe_d[0] = rd_word;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            if (vld_pipe_q[i-1]) dat_pipe_d[i] = dat_pipe_q[i-1];
        end
    end

    // state registers; reset flushes in-flight reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q      <= 1'b0;
            pending_q  <= '0;
            error_q    <= 1'b0;
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
        end else begin
            rdy_q      <= rdy_d;
            pending_q  <= pending_d;
            error_q    <= error_d;
            vld_pipe_q <= vld_pipe_d;
            dat_pipe_q <= dat_pipe_d;
        end
    end

    assign avs.avs_waitrequest   = wait_req;
    assign avs.avs_readdatavalid = rsp_vld;
    assign avs.avs_readdata      = dat_pipe_q[READ_LATENCY-1];
    assign avs.error             = error_q;
endmodule

// File: tb/tb_vx_avs_responder.sv
// Bench for vx_avs_responder: directed vector table, latency/backpressure
// sequence, reset flush sequence and randomized traffic against a
// queue-based reference model.
module tb_vx_avs_responder;
    localparam int DW = 512, AW = 25, BW = 4, NB = 2, MAW = 10, LAT = 4, MAXP = 8;
    localparam int BE = DW / 8;
    localparam int DWB = 32, AWB = 8, MAWB = 4, LATB = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vx_avs_responder_if #(.AVS_DATAW(DW), .AVS_ADDRW(AW), .AVS_BURSTW(BW), .AVS_BANKS(NB)) avs_a ();
    vx_avs_responder_if #(.AVS_DATAW(DWB), .AVS_ADDRW(AWB), .AVS_BURSTW(BW), .AVS_BANKS(NB)) avs_b ();

    vx_avs_responder #(.AVS_DATAW(DW), .AVS_ADDRW(AW), .AVS_BURSTW(BW), .AVS_BANKS(NB),
                       .MEM_ADDRW(MAW), .READ_LATENCY(LAT), .MAX_PENDING(MAXP))
        dut_a (.clk(clk), .reset_n(reset_n), .avs(avs_a));

    vx_avs_responder #(.AVS_DATAW(DWB), .AVS_ADDRW(AWB), .AVS_BURSTW(BW), .AVS_BANKS(NB),
                       .MEM_ADDRW(MAWB), .READ_LATENCY(LATB), .MAX_PENDING(MAXP))
        dut_b (.clk(clk), .reset_n(reset_n), .avs(avs_b));

    int n_chk = 0;
    int n_fail = 0;

    // reference model for dut_a: word store, queue of outstanding reads
    typedef struct { int due; logic [DW-1:0] data; } rd_t;
    rd_t             rq[$];
    logic [DW-1:0]   mmem [int];
    logic [DW-1:0]   exp_last = '0;
    bit              err_m = 1'b0;
    bit              up = 1'b0;
    int              cyc = 0;
    int              stall_seen = 0;

    typedef struct {
        bit            rd;
        bit            wr;
        int            bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BE-1:0] be;
        int            burst;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
    } vec_t;
    vec_t tv[11];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // compare dut_a outputs with the model (called at the falling edge)
    task automatic check_a();
        int pend;
        bit must_wait;
        bit rdv_e;
        pend      = rq.size();
        must_wait = !up || (pend == MAXP);
        rdv_e     = 1'b0;
        if (pend > 0) rdv_e = (rq[0].due == cyc);
`ifdef AVS_STALL_INJECT_EN
        if (must_wait) chk("waitrequest", avs_a.avs_waitrequest, 1);
        else if (avs_a.avs_waitrequest) stall_seen++;
`else
        chk("waitrequest", avs_a.avs_waitrequest, must_wait);
`endif
        chk("readdatavalid", avs_a.avs_readdatavalid, rdv_e);
        if (rdv_e) begin
            exp_last = rq[0].data;
            void'(rq.pop_front());
        end
        chk("readdata", avs_a.avs_readdata, exp_last);
        chk("error", avs_a.error, err_m);
    endtask

    // one bus cycle on dut_a: check, drive, advance the model at the edge
    task automatic cycle_a(input bit rd, input bit wr, input int bank, input logic [AW-1:0] addr,
                           input logic [DW-1:0] d, input logic [BE-1:0] be, input int burst,
                           output bit acc);
        int idx;
        check_a();
        avs_a.avs_read       = rd;
        avs_a.avs_write      = wr;
        avs_a.avs_bankselect = 1'(bank);
        avs_a.avs_address    = addr;
        avs_a.avs_writedata  = d;
        avs_a.avs_byteenable = be;
        avs_a.avs_burstcount = BW'(burst);
        #1;
        acc = (rd || wr) && !avs_a.avs_waitrequest && reset_n;
        @(posedge clk);
        cyc++;
        if (acc) begin
            idx = bank * (1 << MAW) + int'(addr[MAW-1:0]);
            if (wr) begin
                if (!mmem.exists(idx)) mmem[idx] = '0;
                for (int b = 0; b < BE; b++) if (be[b]) mmem[idx][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                rq.push_back('{due: cyc + LAT - 1, data: mmem.exists(idx) ? mmem[idx] : '0});
            end
            if ((rd && wr) || burst != 1) err_m = 1'b1;
        end
        if (reset_n) up = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_a(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle_a(0, 0, 0, '0, '0, '0, 1, acc);
    endtask

    task automatic req_a(input bit rd, input bit wr, input int bank, input logic [AW-1:0] addr,
                         input logic [DW-1:0] d, input logic [BE-1:0] be, input int burst);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 64) begin
            cycle_a(rd, wr, bank, addr, d, be, burst, acc);
            t++;
        end
        chk("accept within bound", acc, 1);
        avs_a.avs_read  = 0;
        avs_a.avs_write = 0;
    endtask

    // after a read accept: count cycles to readdatavalid, then compare data
    task automatic wait_rsp_a(input string name, input logic [DW-1:0] exp);
        int k;
        k = 1;
        while (!avs_a.avs_readdatavalid && k <= 20) begin
            idle_a(1);
            k++;
        end
        chk({name, " latency"}, k, LAT);
        chk({name, " rdata"}, avs_a.avs_readdata, exp);
    endtask

    task automatic write_b(input int a, input logic [DWB-1:0] d);
        int t;
        t = 0;
        avs_b.avs_write      = 1;
        avs_b.avs_address    = AWB'(a);
        avs_b.avs_writedata  = d;
        avs_b.avs_byteenable = '1;
        #1;
        while (avs_b.avs_waitrequest && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("b write accept", t < 50, 1);
        @(negedge clk);
        avs_b.avs_write = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n, rsp_n, c, k, rdv_cnt, done, guard, r;
        int acc_c[9];
        int rsp_c[9];
        logic [DWB-1:0] rsp_d[9];
        logic [AW-1:0]  addr;
        bit acc;

        avs_a.avs_read = 0; avs_a.avs_write = 0; avs_a.avs_address = '0; avs_a.avs_bankselect = '0;
        avs_a.avs_writedata = '0; avs_a.avs_byteenable = '0; avs_a.avs_burstcount = BW'(1);
        avs_b.avs_read = 0; avs_b.avs_write = 0; avs_b.avs_address = '0; avs_b.avs_bankselect = '0;
        avs_b.avs_writedata = '0; avs_b.avs_byteenable = '0; avs_b.avs_burstcount = BW'(1);

        // reset state checked by the model (waitrequest high, all else zero)
        @(negedge clk);
        idle_a(3);
        reset_n = 1'b1;
        idle_a(2);

        // dut_b: backpressure at MAX_PENDING with a long latency
        for (int i = 0; i < 9; i++) write_b(i, 32'hC0DE_0000 + i);
        acc_n = 0; rsp_n = 0; c = 0;
        acc_c = '{default: 0}; rsp_c = '{default: 0};
        while (rsp_n < 9 && c < 400) begin
            if (avs_b.avs_readdatavalid && rsp_n < 9) begin
                rsp_c[rsp_n] = c;
                rsp_d[rsp_n] = avs_b.avs_readdata;
                rsp_n++;
            end
            if (acc_n == 8 && c == acc_c[7] + 1) chk("b wait after 8th accept", avs_b.avs_waitrequest, 1);
            if (acc_n < 9) begin
                avs_b.avs_read    = 1;
                avs_b.avs_address = AWB'(acc_n);
                if (!avs_b.avs_waitrequest) begin
                    acc_c[acc_n] = c;
                    acc_n++;
                end
            end else begin
                avs_b.avs_read = 0;
            end
            @(negedge clk);
            c++;
        end
        avs_b.avs_read = 0;
        chk("b reads accepted", acc_n, 9);
        chk("b responses", rsp_n, 9);
        for (int i = 0; i < 9; i++) chk($sformatf("b order %0d", i), rsp_d[i], 32'hC0DE_0000 + i);
        chk("b first latency", rsp_c[0], acc_c[0] + LATB);
`ifndef AVS_STALL_INJECT_EN
        chk("b 9th accept after first rdv", acc_c[8], rsp_c[0] + 1);
        for (int i = 1; i < 8; i++) chk($sformatf("b back-to-back %0d", i), rsp_c[i], rsp_c[0] + i);
`endif

        // directed vector table on dut_a
        tv[0]  = '{0, 1, 0, 25'd5,    {64{8'hAA}}, {BE{1'b1}}, 1, {DW{1'b0}}, 0};
        tv[1]  = '{1, 0, 0, 25'd5,    {DW{1'b0}},  {BE{1'b0}}, 1, {64{8'hAA}}, 0};
        tv[2]  = '{0, 1, 0, 25'd7,    {64{8'h11}}, {BE{1'b1}}, 1, {DW{1'b0}}, 0};
        tv[3]  = '{0, 1, 0, 25'd7,    {64{8'hFF}}, 64'h1,      1, {DW{1'b0}}, 0};
        tv[4]  = '{1, 0, 0, 25'd7,    {DW{1'b0}},  {BE{1'b0}}, 1, {{63{8'h11}}, 8'hFF}, 0};
        tv[5]  = '{0, 1, 1, 25'd5,    {64{8'h55}}, {BE{1'b1}}, 1, {DW{1'b0}}, 0};
        tv[6]  = '{1, 0, 0, 25'd1029, {DW{1'b0}},  {BE{1'b0}}, 1, {64{8'hAA}}, 0};
        tv[7]  = '{1, 0, 1, 25'd5,    {DW{1'b0}},  {BE{1'b0}}, 1, {64{8'h55}}, 0};
        tv[8]  = '{1, 1, 0, 25'd9,    {16{32'h1234_5678}}, {BE{1'b1}}, 1, {DW{1'b0}}, 1};
        tv[9]  = '{1, 0, 0, 25'd9,    {DW{1'b0}},  {BE{1'b0}}, 1, {16{32'h1234_5678}}, 1};
        tv[10] = '{1, 0, 0, 25'd5,    {DW{1'b0}},  {BE{1'b0}}, 2, {64{8'hAA}}, 1};
        foreach (tv[i]) begin
            req_a(tv[i].rd, tv[i].wr, tv[i].bank, tv[i].addr, tv[i].wdata, tv[i].be, tv[i].burst);
            if (tv[i].rd && !tv[i].wr) wait_rsp_a($sformatf("vec%0d", i), tv[i].exp_rd);
            chk($sformatf("vec%0d error", i), avs_a.error, tv[i].exp_err);
        end
        idle_a(LAT + 2);

        // reset with three reads in flight
        req_a(1, 0, 0, 25'd5, '0, '0, 1);
        req_a(1, 0, 0, 25'd7, '0, '0, 1);
        req_a(1, 0, 0, 25'd9, '0, '0, 1);
        #2;
        reset_n = 1'b0;
        rq.delete();
        exp_last = '0;
        err_m = 1'b0;
        up = 1'b0;
        #1;
        chk("async reset waitrequest", avs_a.avs_waitrequest, 1);
        chk("async reset readdatavalid", avs_a.avs_readdatavalid, 0);
        chk("async reset readdata", avs_a.avs_readdata, '0);
        chk("async reset error", avs_a.error, 0);
        @(negedge clk);
        idle_a(2);
        reset_n = 1'b1;
        rdv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (avs_a.avs_readdatavalid) rdv_cnt++;
            idle_a(1);
        end
        chk("no rdv after reset", rdv_cnt, 0);
        req_a(1, 0, 0, 25'd5, '0, '0, 1);
        wait_rsp_a("post-reset read", {64{8'hAA}});
        req_a(1, 0, 0, 25'd7, '0, '0, 1);
        wait_rsp_a("post-reset read7", {{63{8'h11}}, 8'hFF});

        // randomized traffic against the model
        for (int bk = 0; bk < 2; bk++)
            for (int a = 0; a < 8; a++) req_a(0, 1, bk, AW'(a), rand_word(), {BE{1'b1}}, 1);
        done = 0;
        guard = 0;
        while (done < 1000 && guard < 20000) begin
            r    = $urandom_range(0, 9);
            addr = (AW'($urandom) & ~AW'(1023)) | AW'($urandom_range(0, 7));
            k    = $urandom_range(0, 1);
            cycle_a(r < 4, r >= 4 && r < 7, k, addr, rand_word(),
                    {$urandom, $urandom}, 1, acc);
            if (acc) done++;
            guard++;
        end
        chk("random requests accepted", done, 1000);
        idle_a(LAT + 2);
        chk("reads drained", rq.size(), 0);
`ifdef AVS_STALL_INJECT_EN
        chk("stall observed below MAX_PENDING", stall_seen > 0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
